// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states, ALU/mux selects.
// ALU_Control imports this package for the ALUOp codes.
package mc_pkg;

    // Primary opcodes (instruction bits [31:26])
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    // ALUOp codes consumed by ALU_Control
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBBranch = 2'b11;

    // PC source select
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRExec  = 4'd6,
        StRwb    = 4'd7,
        StBeqEx  = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJEx    = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    // State entered after DECODE; StFetch means the opcode is unsupported.
    function automatic state_t dispatch_state(input logic [5:0] op);
        state_t nxt;
        case (op)
            OpLw, OpSw: nxt = StMemAdr;
            OpRtype:    nxt = StRExec;
            OpBeq:      nxt = StBeqEx;
            OpAddi:     nxt = StAddiEx;
            OpJ:        nxt = StJEx;
            default:    nxt = StFetch;
        endcase
        return nxt;
    endfunction

    function automatic logic is_supported_op(input logic [5:0] op);
        return dispatch_state(op) != StFetch;
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decoder: maps the current state to datapath controls.
// mem_ready only gates the FETCH-cycle IR/PC write enables.
module mc_output_decode
    import mc_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            StFetch: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SrcBFour;
                ctrl.alu_op    = AluOpAdd;
                ctrl.pc_src    = PcSrcAlu;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            StDecode: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SrcBBranch;
                ctrl.alu_op    = AluOpAdd;
            end
            StMemAdr: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = AluOpAdd;
            end
            StMemRd: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            StMemWr: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            StRExec: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBReg;
                ctrl.alu_op    = AluOpFunct;
            end
            StRwb: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
            end
            StBeqEx: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBReg;
                ctrl.alu_op    = AluOpSub;
                ctrl.branch    = 1'b1;
                ctrl.pc_src    = PcSrcAluOut;
            end
            StAddiEx: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = AluOpAdd;
            end
            StAddiWb: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
            end
            StJEx: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PcSrcJump;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset main controller: state register, next-state logic and
// output decode, with optional memory-wait handshaking.
module multicycle_control
    import mc_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic [3:0] state,
    output logic       illegal_op
);

    state_t state_q, state_d;
    state_t dec_state;
    ctrl_t  dec_ctrl;
    logic   mem_ok;

    assign mem_ok = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = mem_ok ? StDecode : StFetch;
            StDecode: state_d = dispatch_state(opcode);
            StMemAdr: begin
                if (opcode == OpLw) begin
                    state_d = StMemRd;
                end else if (opcode == OpSw) begin
                    state_d = StMemWr;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemRd:  state_d = mem_ok ? StMemWb : StMemRd;
            StMemWb:  state_d = StFetch;
            StMemWr:  state_d = mem_ok ? StFetch : StMemWr;
            StRExec:  state_d = StRwb;
            StRwb:    state_d = StFetch;
            StBeqEx:  state_d = StFetch;
            StAddiEx: state_d = StAddiWb;
            StAddiWb: state_d = StFetch;
            StJEx:    state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // During reset the outputs show FETCH values even before the first edge.
    assign dec_state = reset ? StFetch : state_q;

    mc_output_decode u_output_decode (
        .state     (dec_state),
        .mem_ready (mem_ok),
        .ctrl      (dec_ctrl)
    );

    always_comb begin
        PCWrite    = dec_ctrl.pc_write  & ~reset;
        Branch     = dec_ctrl.branch;
        IorD       = dec_ctrl.iord;
        MemRead    = dec_ctrl.mem_read  & ~reset;
        MemWrite   = dec_ctrl.mem_write & ~reset;
        IRWrite    = dec_ctrl.ir_write  & ~reset;
        RegDst     = dec_ctrl.reg_dst;
        MemtoReg   = dec_ctrl.mem_to_reg;
        ALUSrcA    = dec_ctrl.alu_src_a;
        RegWrite   = dec_ctrl.reg_write & ~reset;
        ALUSrcB    = dec_ctrl.alu_src_b;
        ALUOp      = dec_ctrl.alu_op;
        PCSrc      = dec_ctrl.pc_src;
        illegal_op = ~reset & (state_q == StDecode) & ~is_supported_op(opcode);
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control plus per-instruction cycle counts.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, ALUSrcA, RegWrite;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] state;
    logic       illegal_op;
    logic [16:0] act;

    multicycle_control #(
        .MEM_WAIT_EN (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .RegWrite   (RegWrite),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSrc      (PCSrc),
        .state      (state),
        .illegal_op (illegal_op)
    );

    // {PCWrite,Branch,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,ALUSrcA,RegWrite,
    //  ALUSrcB,ALUOp,PCSrc,illegal_op}
    assign act = {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                  ALUSrcA, RegWrite, ALUSrcB, ALUOp, PCSrc, illegal_op};

    localparam logic [16:0] C_RST     = 17'b0_0_0_0_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FETCH_W = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FETCH_R = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_DEC_ILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] C_MEMADR  = 17'b0_0_0_0_0_0_0_0_1_0_10_00_00_0;
    localparam logic [16:0] C_MEMRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MEMWB   = 17'b0_0_0_0_0_0_0_1_0_1_00_00_00_0;
    localparam logic [16:0] C_MEMWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_REXEC   = 17'b0_0_0_0_0_0_0_0_1_0_00_10_00_0;
    localparam logic [16:0] C_RWB     = 17'b0_0_0_0_0_0_1_0_0_1_00_00_00_0;
    localparam logic [16:0] C_BEQ     = 17'b0_1_0_0_0_0_0_0_1_0_00_01_01_0;
    localparam logic [16:0] C_ADDIEX  = 17'b0_0_0_0_0_0_0_0_1_0_10_00_00_0;
    localparam logic [16:0] C_ADDIWB  = 17'b0_0_0_0_0_0_0_0_0_1_00_00_00_0;
    localparam logic [16:0] C_JEX     = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ctrl;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [5:0] o, input logic rd,
                       input logic [3:0] s, input logic [16:0] c);
        vec_t v;
        v.rst  = r;
        v.op   = o;
        v.rdy  = rd;
        v.st   = s;
        v.ctrl = c;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [16:0] got,
                       input logic [16:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d]: got=%b want=%b", nm, idx, got, want);
        end
    endtask

    // Runs one instruction from FETCH back to FETCH with mem_ready=1 and checks its length.
    task automatic run_count(input logic [5:0] op, input int exp_cycles, input int idx);
        int n;
        n = 0;
        chk("count_start_state", idx, {13'd0, state}, 17'd0);
        opcode    = op;
        mem_ready = 1'b1;
        reset     = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (state == 4'd0) break;
        end
        chk("cycle_count", idx, 17'(n), 17'(exp_cycles));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        opcode    = OP_R;
        mem_ready = 1'b1;

        // R-type, mem_ready ignored outside memory states
        add(1, OP_R, 1, 0, C_RST);
        add(0, OP_R, 1, 0, C_FETCH_R);
        add(0, OP_R, 0, 1, C_DECODE);
        add(0, OP_R, 0, 6, C_REXEC);
        add(0, OP_R, 1, 7, C_RWB);
        // LW with two wait cycles in FETCH and MEMRD
        add(0, OP_LW, 0, 0, C_FETCH_W);
        add(0, OP_LW, 0, 0, C_FETCH_W);
        add(0, OP_LW, 1, 0, C_FETCH_R);
        add(0, OP_LW, 1, 1, C_DECODE);
        add(0, OP_LW, 1, 2, C_MEMADR);
        add(0, OP_LW, 0, 3, C_MEMRD);
        add(0, OP_LW, 0, 3, C_MEMRD);
        add(0, OP_LW, 1, 3, C_MEMRD);
        add(0, OP_LW, 1, 4, C_MEMWB);
        // SW with one wait cycle
        add(0, OP_SW, 1, 0, C_FETCH_R);
        add(0, OP_SW, 1, 1, C_DECODE);
        add(0, OP_SW, 1, 2, C_MEMADR);
        add(0, OP_SW, 0, 5, C_MEMWR);
        add(0, OP_SW, 1, 5, C_MEMWR);
        // BEQ then J
        add(0, OP_BEQ, 1, 0, C_FETCH_R);
        add(0, OP_BEQ, 1, 1, C_DECODE);
        add(0, OP_BEQ, 1, 8, C_BEQ);
        add(0, OP_J, 1, 0, C_FETCH_R);
        add(0, OP_J, 1, 1, C_DECODE);
        add(0, OP_J, 1, 11, C_JEX);
        // ADDI
        add(0, OP_ADDI, 1, 0, C_FETCH_R);
        add(0, OP_ADDI, 1, 1, C_DECODE);
        add(0, OP_ADDI, 1, 9, C_ADDIEX);
        add(0, OP_ADDI, 1, 10, C_ADDIWB);
        // Illegal opcode twice in a row
        add(0, OP_BAD, 1, 0, C_FETCH_R);
        add(0, OP_BAD, 1, 1, C_DEC_ILL);
        add(0, OP_BAD, 1, 0, C_FETCH_R);
        add(0, OP_BAD, 0, 1, C_DEC_ILL);
        // Reset during MEMRD wait, then a normal LW
        add(0, OP_LW, 1, 0, C_FETCH_R);
        add(0, OP_LW, 1, 1, C_DECODE);
        add(0, OP_LW, 1, 2, C_MEMADR);
        add(0, OP_LW, 0, 3, C_MEMRD);
        add(1, OP_LW, 0, 3, C_RST);
        add(1, OP_LW, 0, 0, C_RST);
        add(0, OP_LW, 1, 0, C_FETCH_R);
        add(0, OP_LW, 1, 1, C_DECODE);
        add(0, OP_LW, 1, 2, C_MEMADR);
        add(0, OP_LW, 1, 3, C_MEMRD);
        add(0, OP_LW, 1, 4, C_MEMWB);
        // Reset during MEMWR wait
        add(0, OP_SW, 1, 0, C_FETCH_R);
        add(0, OP_SW, 1, 1, C_DECODE);
        add(0, OP_SW, 1, 2, C_MEMADR);
        add(0, OP_SW, 0, 5, C_MEMWR);
        add(1, OP_SW, 0, 5, C_RST);
        add(0, OP_SW, 0, 0, C_FETCH_W);

        @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset     = vecs[i].rst;
            opcode    = vecs[i].op;
            mem_ready = vecs[i].rdy;
            #1;
            chk("state", i, {13'd0, state}, {13'd0, vecs[i].st});
            chk("ctrl", i, act, vecs[i].ctrl);
        end

        // Cycle counts with mem_ready=1, starting from FETCH
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_count(OP_R, 4, 0);
        run_count(OP_LW, 5, 1);
        run_count(OP_SW, 4, 2);
        run_count(OP_BEQ, 3, 3);
        run_count(OP_ADDI, 4, 4);
        run_count(OP_J, 3, 5);
        run_count(OP_BAD, 2, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
